muldiv_sequencer: RTL

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from decode through a start/busy/done handshake. It runs a 32-iteration shift-add or restoring-divide loop, then writes the 64-bit result to HI/LO. The single-cycle ALU keeps AND/OR/ADD/SUB/SLT/shift/LUI/MOVZ. MFHI/MFLO read this block's `hi`/`lo` outputs, and decode stalls on `busy`.

---
 rtl/muldiv_sequencer_if.sv | 14 +
 rtl/muldiv_sequencer.sv | 81 ++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: decode-to-sequencer mul/div request handshake and HI/LO readout
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic start;
  logic [2:0] op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic flush;
  logic busy;
  logic done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  modport master(output start, op, rs_val, rt_val, flush, input busy, done, hi, lo);
  modport slave(input start, op, rs_val, rt_val, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiply / restoring divide owning the HI/LO registers
module muldiv_sequencer #(parameter int XLEN = 32) (
  input logic clk,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, dnext, mres;
  logic [XLEN-1:0] a, b, mag_a, mag_b, quo, rem;
  logic [XLEN:0] msum, dtry;
  logic is_div, neg_a, neg_b, sa, sb;
  always_comb begin
    sa = bus.op[0] & bus.rs_val[XLEN-1];
    sb = bus.op[0] & bus.rt_val[XLEN-1];
    mag_a = sa ? -bus.rs_val : bus.rs_val;
    mag_b = sb ? -bus.rt_val : bus.rt_val;
    msum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, a & {XLEN{b[0]}}};
    // a doubles as the dividend shift register, feeding its MSB into the partial remainder
    dtry = {acc[2*XLEN-1:XLEN], a[XLEN-1]} - {1'b0, b};
    dnext = {dtry[XLEN] ? {acc[2*XLEN-2:XLEN], a[XLEN-1]} : dtry[XLEN-1:0], acc[XLEN-2:0], ~dtry[XLEN]};
    mres = (neg_a ^ neg_b) ? -acc : acc;
    quo = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      a <= '0;
      b <= '0;
      is_div <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.op[2]) begin
            a <= mag_a;
            b <= mag_b;
            neg_a <= sa;
            neg_b <= sb;
            is_div <= ~bus.op[1];
            acc <= '0;
            cnt <= '0;
            bus.busy <= 1'b1;
            state <= CALC;
          end else if (bus.start && bus.op[2:1] == 2'b10) begin
            if (bus.op[0]) bus.hi <= bus.rs_val;
            else bus.lo <= bus.rs_val;
          end
        end
        CALC: begin
          acc <= is_div ? dnext : {msum, acc[XLEN-1:1]};
          a <= is_div ? a << 1 : a;
          b <= is_div ? b : b >> 1;
          cnt <= cnt + CW'(1);
          state <= (cnt == CW'(XLEN-1)) ? FIX : CALC;
        end
        default: begin
          {bus.hi, bus.lo} <= is_div ? {rem, quo} : mres;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
